// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared types and constants for the four-digit BCD counter
package counters_pkg;

  typedef logic [3:0] bcd_t;

  localparam int          DIGITS   = 4;
  localparam logic [15:0] MAX_BCD  = 16'h9675;
  localparam bcd_t        BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decade counter stage; clr beats inc, inc at nine wraps to zero
module bcd_digit
  import counters_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output bcd_t q,
  output logic nine
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      // A stray non-BCD value also falls back to zero here rather than counting on.
      q_d = (q_q >= BCD_NINE) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign nine = (q_q == BCD_NINE);

endmodule

// File: rtl/counters_controller.sv
// rtl/counters_controller.sv - four cascaded decade digits counting 0000..9675 with per-digit clear flags
module counters_controller
  import counters_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  output logic [15:0]       Qdata,
  output logic [DIGITS-1:0] blink
);

  bcd_t              digit_q [DIGITS];
  logic [DIGITS-1:0] nine;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] clr;
  logic              at_max;

  assign at_max = (Qdata == MAX_BCD);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    localparam logic [DIGITS-1:0] LOWER_M = DIGITS'((1 << i) - 1);
    localparam logic [DIGITS-1:0] UPTO_M  = DIGITS'((1 << (i + 1)) - 1);

    // Carry is a pure AND of the lower nine flags so the whole ripple settles in one cycle.
    assign inc[i]   = ena & ((nine & LOWER_M) == LOWER_M);
    assign clr[i]   = ena & (at_max | (digit_q[i] > BCD_NINE));
    assign blink[i] = ena & rst & (((nine & UPTO_M) == UPTO_M) | at_max);
    assign Qdata[4*i +: 4] = digit_q[i];

    bcd_digit u_digit (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[i]),
      .clr  (clr[i]),
      .q    (digit_q[i]),
      .nine (nine[i])
    );
  end

endmodule

// File: tb/tb_counters_controller.sv
// tb/tb_counters_controller.sv - directed self-checking bench for counters_controller
module tb_counters_controller;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] Qdata;
  logic [3:0]  blink;

  int n_cmp = 0;
  int n_err = 0;
  int range_viol = 0;

  counters_controller dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .Qdata (Qdata),
    .blink (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Watch every sampled value for out-of-range or non-BCD digits.
  always @(negedge clk) begin
    if (Qdata > 16'h9675 || Qdata[3:0] > 4'd9 || Qdata[7:4] > 4'd9 ||
        Qdata[11:8] > 4'd9 || Qdata[15:12] > 4'd9)
      range_viol++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    ena = 1'b1;
    step(3);
    check_eq("rst_qdata", Qdata, 16'h0000);
    check_eq("rst_blink", {12'h0, blink}, 16'h0000);

    // 1: first ten enabled edges
    rst = 1'b1;
    step(9);
    check_eq("t1_q0009", Qdata, 16'h0009);
    check_eq("t1_blink0009", {12'h0, blink}, 16'h0001);
    step(1);
    check_eq("t1_q0010", Qdata, 16'h0010);
    check_eq("t1_blink0010", {12'h0, blink}, 16'h0000);

    // 2: tens and hundreds carries
    step(89);
    check_eq("t2_q0099", Qdata, 16'h0099);
    check_eq("t2_blink0099", {12'h0, blink}, 16'h0003);
    step(1);
    check_eq("t2_q0100", Qdata, 16'h0100);
    step(899);
    check_eq("t2_q0999", Qdata, 16'h0999);
    check_eq("t2_blink0999", {12'h0, blink}, 16'h0007);
    step(1);
    check_eq("t2_q1000", Qdata, 16'h1000);

    // 3: full period from reset
    do_reset();
    range_viol = 0;
    step(9675);
    check_eq("t3_q9675", Qdata, 16'h9675);
    check_eq("t3_blink9675", {12'h0, blink}, 16'h000F);
    step(1);
    check_eq("t3_wrap", Qdata, 16'h0000);
    check_eq("t3_blink_wrap", {12'h0, blink}, 16'h0000);
    check_eq("t3_range", 16'(range_viol), 16'h0000);

    // 4: hold
    do_reset();
    step(457);
    check_eq("t4_q0457", Qdata, 16'h0457);
    ena = 1'b0;
    step(25);
    check_eq("t4_hold", Qdata, 16'h0457);
    check_eq("t4_blink_hold", {12'h0, blink}, 16'h0000);
    ena = 1'b1;
    step(1);
    check_eq("t4_q0458", Qdata, 16'h0458);

    // 5: asynchronous reset mid-cycle
    step(3541);
    check_eq("t5_q3999", Qdata, 16'h3999);
    check_eq("t5_blink3999", {12'h0, blink}, 16'h0007);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t5_async_q", Qdata, 16'h0000);
    check_eq("t5_async_blink", {12'h0, blink}, 16'h0000);
    step(1);
    check_eq("t5_held_q", Qdata, 16'h0000);
    check_eq("t5_held_blink", {12'h0, blink}, 16'h0000);
    rst = 1'b1;

    // 6: ena toggling around terminal count
    do_reset();
    step(9674);
    check_eq("t6_q9674", Qdata, 16'h9674);
    ena = 1'b0;
    step(1);
    check_eq("t6_hold9674", Qdata, 16'h9674);
    ena = 1'b1;
    step(1);
    check_eq("t6_q9675", Qdata, 16'h9675);
    ena = 1'b0;
    step(1);
    check_eq("t6_hold9675", Qdata, 16'h9675);
    check_eq("t6_blink_off", {12'h0, blink}, 16'h0000);
    ena = 1'b1;
    #1;
    check_eq("t6_blink_on", {12'h0, blink}, 16'h000F);
    step(1);
    check_eq("t6_q0000", Qdata, 16'h0000);
    ena = 1'b0;
    step(1);
    check_eq("t6_hold0000", Qdata, 16'h0000);
    ena = 1'b1;
    step(1);
    check_eq("t6_q0001", Qdata, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
